// File: rtl/spi_cmd_slave_if.sv
// Parallel command/response handshake between spi_cmd_slave and the command decoder.
// slave modport = the SPI block, master modport = the decoder / register map.
interface spi_cmd_slave_if #(
    parameter int LEN_SPI      = 32,
    parameter int SPI_CODE_LEN = 6,
    parameter int SPI_ADDR_LEN = 10,
    parameter int SPI_DATA_LEN = 16
);
    // valid/ready: a transfer happens on a clock edge where valid & ready are both 1;
    // the source holds valid and its payload stable until that edge.
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [SPI_CODE_LEN-1:0] cmd_code;
    logic [SPI_ADDR_LEN-1:0] cmd_addr;
    logic [SPI_DATA_LEN-1:0] cmd_data;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [LEN_SPI-1:0]      rsp_data;

    modport slave (
        output cmd_valid, cmd_code, cmd_addr, cmd_data,
        input  cmd_ready,
        input  rsp_valid, rsp_data,
        output rsp_ready
    );

    modport master (
        input  cmd_valid, cmd_code, cmd_addr, cmd_data,
        output cmd_ready,
        output rsp_valid, rsp_data,
        input  rsp_ready
    );
endinterface

// File: rtl/spi_cmd_slave.sv
// Oversampled SPI slave: 32-bit LSB-first command frames in, response word out on miso.
// Optional macro SPI_ECHO_EN: with no pending response, the next frame echoes the last one.
module spi_cmd_slave #(
    parameter int LEN_SPI      = 32,
    parameter int SPI_CODE_LEN = 6,
    parameter int SPI_ADDR_LEN = 10,
    parameter int SPI_DATA_LEN = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                  clk_50M,
    input  logic                  rst,
    input  logic                  sck,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  frame_err,
    output logic                  overrun,
    output logic [1:0]            dbg_state,
    spi_cmd_slave_if.slave        cmd_if
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(LEN_SPI + 2);
    localparam int IDX_W = $clog2(LEN_SPI);
    localparam logic [CNT_W-1:0] CNT_LEN = CNT_W'(LEN_SPI);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LEN_SPI + 1);

    logic [SYNC_STAGES-1:0]  sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0]  cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0]  mosi_sync_q, mosi_sync_d;
    logic                    sck_prev_q, sck_prev_d;
    logic                    cs_prev_q, cs_prev_d;
    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [LEN_SPI-1:0]      rx_shift_q, rx_shift_d;
    logic [LEN_SPI-1:0]      tx_shift_q, tx_shift_d;
    logic                    pending_q, pending_d;
    logic                    rsp_ready_q, rsp_ready_d;
    logic                    cmd_valid_q, cmd_valid_d;
    logic [SPI_CODE_LEN-1:0] cmd_code_q, cmd_code_d;
    logic [SPI_ADDR_LEN-1:0] cmd_addr_q, cmd_addr_d;
    logic [SPI_DATA_LEN-1:0] cmd_data_q, cmd_data_d;
    logic                    frame_err_q, frame_err_d;
    logic                    overrun_q, overrun_d;

    logic sck_s, cs_s, mosi_s, sck_fall, cs_fall, cs_rise, rsp_accept;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_fall = sck_prev_q & ~sck_s;
    // cs history resets low so a frame cut by reset needs a fresh high->low edge
    assign cs_fall  = cs_prev_q & ~cs_s;
    assign cs_rise  = ~cs_prev_q & cs_s;
    assign rsp_accept = cmd_if.rsp_valid & rsp_ready_q;

    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sck_prev_d  = sck_s;
        cs_prev_d   = cs_s;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        pending_d   = pending_q;
        cmd_valid_d = cmd_valid_q;
        cmd_code_d  = cmd_code_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_data_d  = cmd_data_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;

        if (cmd_valid_q && cmd_if.cmd_ready) begin
            cmd_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (rsp_accept) begin
                    tx_shift_d = cmd_if.rsp_data;
                    pending_d  = 1'b1;
                end
                if (cs_fall) begin
                    state_d    = ST_SHIFT;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                end
            end
            ST_SHIFT: begin
                // a fall seen together with the cs rise still belongs to this frame
                if (sck_fall) begin
                    if (bit_cnt_q < CNT_LEN) begin
                        rx_shift_d[bit_cnt_q[IDX_W-1:0]] = mosi_s;
                    end
                    if (bit_cnt_q != CNT_MAX) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                    tx_shift_d = tx_shift_q >> 1;
                end
                if (cs_rise) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d   = ST_IDLE;
                pending_d = 1'b0;
`ifdef SPI_ECHO_EN
                tx_shift_d = pending_q ? '0 : rx_shift_q;
`else
                tx_shift_d = '0;
`endif
                if (bit_cnt_q != CNT_LEN) begin
                    frame_err_d = 1'b1;
                end else if (rx_shift_q[LEN_SPI-1 -: SPI_CODE_LEN] == '0) begin
                    cmd_valid_d = cmd_valid_d;
                end else if (cmd_valid_q) begin
                    overrun_d = 1'b1;
                end else begin
                    cmd_valid_d = 1'b1;
                    cmd_code_d  = rx_shift_q[LEN_SPI-1 -: SPI_CODE_LEN];
                    cmd_addr_d  = rx_shift_q[SPI_DATA_LEN +: SPI_ADDR_LEN];
                    cmd_data_d  = rx_shift_q[SPI_DATA_LEN-1:0];
                end
            end
            default: state_d = ST_IDLE;
        endcase

        rsp_ready_d = (state_d == ST_IDLE) && !pending_d;
    end

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            sck_sync_q  <= '1;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b1;
            cs_prev_q   <= 1'b0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            pending_q   <= 1'b0;
            rsp_ready_q <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= '0;
            cmd_addr_q  <= '0;
            cmd_data_q  <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sck_sync_q  <= sck_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sck_prev_q  <= sck_prev_d;
            cs_prev_q   <= cs_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            pending_q   <= pending_d;
            rsp_ready_q <= rsp_ready_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_data_q  <= cmd_data_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign miso             = tx_shift_q[0];
    assign frame_err        = frame_err_q;
    assign overrun          = overrun_q;
    assign dbg_state        = state_q;
    assign cmd_if.cmd_valid = cmd_valid_q;
    assign cmd_if.cmd_code  = cmd_code_q;
    assign cmd_if.cmd_addr  = cmd_addr_q;
    assign cmd_if.cmd_data  = cmd_data_q;
    assign cmd_if.rsp_ready = rsp_ready_q;
endmodule
